uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//  Byte-level UART transmitter/receiver for the ring-buffered UART peripheral.
//  It converts the peripheral's parallel load/strobe interface to and from 8N1 serial on txpin/rxpin.
//  Bit timing comes from an external oversample enable, bitxce, supplied by the peripheral's divider.
//  Full duplex: the TX and RX paths are independent state machines sharing clk, resetn and bitxce.
// PARAMETERS
//  OVERSAMPLE  8  bitxce pulses per bit time; power of two, 4..16
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  resetn    in   1  asynchronous active-low reset
//  bitxce    in   1  one-clk enable pulse, OVERSAMPLE times per bit period
//  load      in   1  one-clk strobe: start sending d; honoured only while txbusy=0
//  d         in   8  TX byte, sampled on the load cycle
//  txbusy    out  1  high from the cycle after an accepted load until the stop bit ends
//  txpin     out  1  serial output, idle high
//  rxpin     in   1  serial input, asynchronous
//  bytercvd  out  1  one-clk pulse: a valid byte is on q
//  q         out  8  last good received byte; held until the next good byte
//  frame_err out  1  one-clk pulse: stop bit sampled low
//  rxst      out  2  RX state (0 IDLE, 1 START, 2 DATA, 3 STOP/BREAK), debug only
// BEHAVIOUR
//  Reset values (async, resetn=0): txpin=1, txbusy=0, bytercvd=0, q=0, frame_err=0, rxst=0.
//   Both FSMs go to IDLE, counters clear, RX synchronizer flops preset to 1.
//   Reset mid-frame aborts it: txpin returns high immediately, and no partial byte is reported.
//  Timing: ticks counted in a log2(OVERSAMPLE)-bit counter, advanced only on clk edges with bitxce=1.
//  TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
//   - IDLE: on load=1, latch d into the shift register, clear the tick counter, enter START.
//     txbusy=1 and txpin=0 from the next cycle.
//   - Each bit holds for exactly OVERSAMPLE bitxce ticks.
//     START drives 0; DATA sends 8 bits LSB first; STOP drives 1.
//   - After the last stop tick: txbusy=0 in the same cycle, back to IDLE.
//     A load on that same cycle is accepted (back-to-back, no idle gap).
//   - load while txbusy=1 is ignored; d is not re-sampled.
//  RX FSM:
//   - rxpin passes through a 2-flop synchronizer (rx_s); all decisions use rx_s on bitxce cycles.
//   - IDLE: rx_s=0 on a bitxce -> START, tick counter=1.
//   - START: at tick OVERSAMPLE/2 re-check rx_s. If 1: false start, go to IDLE with no pulse.
//     If 0: counter=0, enter DATA.
//   - DATA: sample rx_s every OVERSAMPLE ticks (mid-bit); shift in LSB first. After 8 samples enter STOP.
//   - STOP: sample after OVERSAMPLE ticks.
//     If 1: q<=shift register and bytercvd=1 for exactly one clk, then IDLE.
//     If 0: frame_err=1 for one clk, q unchanged, enter BREAK (rxst=3).
//   - BREAK: stay until rx_s=1 on a bitxce, then IDLE. A held-low line yields one frame_err, not repeats.
//  Simultaneity and latency:
//   - bytercvd and an accepted load may coincide; TX and RX never stall each other.
//   - A bitxce arriving on the load cycle is not counted toward the start bit.
//   - Frame length: 10*OVERSAMPLE ticks.
//   - RX latency: bytercvd fires OVERSAMPLE/2 + 9*OVERSAMPLE ticks after the synchronized falling edge, +/-1 tick.
//  bitxce stuck low freezes both FSMs with outputs held; there is no timeout.
// TESTING (OVERSAMPLE=8; bitxce every 13 clks; txpin looped to rxpin unless stated)
//  1. load with d=8'hA5 -> txpin shows 0,1,0,1,0,0,1,0,1,1, each bit 104 clks;
//     bytercvd pulses once, q=8'hA5, txbusy low after 1040 clks.
//  2. Back-to-back loads 8'h00 then 8'hFF, second load on the txbusy-falling cycle
//     -> no idle gap, q=8'h00 then 8'hFF, two bytercvd pulses.
//  3. load pulsed while txbusy=1 with d=8'h3C during an 8'h55 frame -> only 8'h55 sent; d change ignored.
//  4. rxpin driven low for 3 ticks then high (glitch) -> no bytercvd, no frame_err, rxst back to 0.
//  5. Frame 8'h81 with the stop bit forced low, line held low 30 ticks, then high
//     -> one frame_err pulse, q keeps its old value, rxst=3 until the line is high, then 0.
//  6. Assert resetn=0 mid-data-bit of a TX and an RX frame -> txpin=1, txbusy=0 immediately;
//     no bytercvd; a clean 8'h5A frame after release is received correctly.

Source files
------------

// File: rtl/uart_core.sv
// 8N1 UART byte transmitter/receiver timed by an external oversample enable.
// TX and RX are independent FSMs sharing clk, resetn and bitxce.
module uart_core #(
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       bitxce,
    input  logic       load,
    input  logic [7:0] d,
    output logic       txbusy,
    output logic       txpin,
    input  logic       rxpin,
    output logic       bytercvd,
    output logic [7:0] q,
    output logic       frame_err,
    output logic [1:0] rxst
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [TW-1:0]     tx_tick_q, tx_tick_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_sh_q, tx_sh_d;
    logic              txpin_q, txpin_d;
    logic              txbusy_q, txbusy_d;

    rx_state_e         rx_state_q, rx_state_d;
    logic [TW-1:0]     rx_tick_q, rx_tick_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic              rx_s1_q, rx_s_q;
    logic [7:0]        q_q, q_d;
    logic              bytercvd_q, bytercvd_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        rxst_q, rxst_d;

    assign txpin     = txpin_q;
    assign txbusy    = txbusy_q;
    assign q         = q_q;
    assign bytercvd  = bytercvd_q;
    assign frame_err = frame_err_q;
    assign rxst      = rxst_q;

    // TX state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txpin_q    <= 1'b1;
            txbusy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txpin_q    <= txpin_d;
            txbusy_q   <= txbusy_d;
        end
    end

    // TX next state; the pin level for each bit is registered as the bit begins
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txpin_d    = txpin_q;
        txbusy_d   = txbusy_q;
        case (tx_state_q)
            TX_IDLE: begin
                txpin_d  = 1'b1;
                txbusy_d = 1'b0;
                if (load) begin
                    tx_sh_d    = d;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                    txpin_d    = 1'b0;
                    txbusy_d   = 1'b1;
                end
            end
            TX_START: begin
                if (bitxce) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        tx_state_d = TX_DATA;
                        txpin_d    = tx_sh_q[0];
                    end
                end
            end
            TX_DATA: begin
                if (bitxce) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                            txpin_d    = 1'b1;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                            txpin_d  = tx_sh_q[1];
                        end
                    end
                end
            end
            TX_STOP: begin
                if (bitxce) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                    if (tx_tick_q == TICK_LAST) begin
                        tx_state_d = TX_IDLE;
                        txbusy_d   = 1'b0;
                        txpin_d    = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX synchronizer and state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            q_q         <= '0;
            bytercvd_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rxst_q      <= 2'd0;
        end else begin
            rx_s1_q     <= rxpin;
            rx_s_q      <= rx_s1_q;
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            q_q         <= q_d;
            bytercvd_q  <= bytercvd_d;
            frame_err_q <= frame_err_d;
            rxst_q      <= rxst_d;
        end
    end

    // RX next state; the start bit is re-checked half a bit in so later samples land mid-bit
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        q_d         = q_q;
        bytercvd_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (bitxce && !rx_s_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = TW'(1);
                end
            end
            RX_START: begin
                if (bitxce) begin
                    rx_tick_d = rx_tick_q + TW'(1);
                    if (rx_tick_q == TICK_HALF) begin
                        if (rx_s_q) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_tick_d  = '0;
                            rx_bit_d   = '0;
                        end
                    end
                end
            end
            RX_DATA: begin
                if (bitxce) begin
                    rx_tick_d = rx_tick_q + TW'(1);
                    if (rx_tick_q == TICK_LAST) begin
                        rx_sh_d = {rx_s_q, rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (bitxce) begin
                    rx_tick_d = rx_tick_q + TW'(1);
                    if (rx_tick_q == TICK_LAST) begin
                        if (rx_s_q) begin
                            q_d        = rx_sh_q;
                            bytercvd_d = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            rx_state_d  = RX_BREAK;
                        end
                    end
                end
            end
            RX_BREAK: begin
                if (bitxce && rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        case (rx_state_d)
            RX_IDLE:  rxst_d = 2'd0;
            RX_START: rxst_d = 2'd1;
            RX_DATA:  rxst_d = 2'd2;
            default:  rxst_d = 2'd3;
        endcase
    end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: loopback TX->RX plus directly driven RX frames,
// bitxce every 13 clks with OVERSAMPLE=8.
module tb_uart_core;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       bitxce = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = 8'h00;
    logic       txbusy, txpin, rxpin, bytercvd, frame_err;
    logic [7:0] q;
    logic [1:0] rxst;
    logic       loop_en = 1'b1;
    logic       rx_drv = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int fe_cnt = 0;
    int rst_gen = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    assign rxpin = loop_en ? txpin : rx_drv;

    always #5 clk = ~clk;

    uart_core #(.OVERSAMPLE(8)) dut (
        .clk(clk), .resetn(resetn), .bitxce(bitxce), .load(load), .d(d),
        .txbusy(txbusy), .txpin(txpin), .rxpin(rxpin), .bytercvd(bytercvd),
        .q(q), .frame_err(frame_err), .rxst(rxst)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic gen_bitxce();
        forever begin
            repeat (12) @(negedge clk);
            bitxce = 1'b1;
            @(negedge clk);
            bitxce = 1'b0;
        end
    endtask

    // Pops an expected byte for every bytercvd; counts frame errors
    task automatic rx_mon();
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && bytercvd === 1'b1) begin
                rx_cnt++;
                if (rx_exp_q.size() == 0)
                    check("rx_unexpected", 32'(rx_exp_q.size()), 32'd1);
                else
                    check("rx_byte", 32'(q), 32'(rx_exp_q.pop_front()));
            end
            if (resetn === 1'b1 && frame_err === 1'b1) fe_cnt++;
        end
    endtask

    // Decodes txpin frames by sampling near mid-bit after each falling edge
    task automatic tx_mon();
        logic [9:0] fr;
        int g;
        forever begin
            @(negedge txpin);
            g = rst_gen;
            for (int k = 0; k < 10; k++) begin
                repeat ((k == 0) ? 50 : 104) @(negedge clk);
                fr[k] = txpin;
            end
            if (g == rst_gen) begin
                if (tx_exp_q.size() == 0)
                    check("tx_unexpected", 32'(tx_exp_q.size()), 32'd1);
                else
                    check("tx_frame", 32'(fr), 32'({1'b1, tx_exp_q.pop_front(), 1'b0}));
            end
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        d = b;
        load = 1'b1;
        tx_exp_q.push_back(b);
        if (loop_en) rx_exp_q.push_back(b);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || txbusy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n >= 4000), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_txpin", 32'(txpin), 32'd1);
        check("rst_txbusy", 32'(txbusy), 32'd0);
        check("rst_bytercvd", 32'(bytercvd), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rxst", 32'(rxst), 32'd0);
    endtask

    initial begin
        int n, c0, f0;
        logic [8:0] bits;

        fork
            gen_bitxce();
            rx_mon();
            tx_mon();
        join_none

        repeat (3) @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single frame, busy window length and loopback receive
        c0 = rx_cnt;
        send_tx(8'hA5);
        check("t1_busy_next", 32'(txbusy), 32'd1);
        check("t1_start_low", 32'(txpin), 32'd0);
        n = 0;
        while (txbusy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_len", 32'(n >= 1028 && n <= 1041), 32'd1);
        wait_idle("t1_timeout");
        check("t1_rx_count", 32'(rx_cnt - c0), 32'd1);
        check("t1_q", 32'(q), 32'hA5);

        // 2: back-to-back, second load on the txbusy-falling cycle
        repeat (20) @(negedge clk);
        c0 = rx_cnt;
        send_tx(8'h00);
        n = 0;
        while (txbusy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        send_tx(8'hFF);
        check("t2_busy_again", 32'(txbusy), 32'd1);
        check("t2_no_gap", 32'(txpin), 32'd0);
        wait_idle("t2_timeout");
        check("t2_rx_count", 32'(rx_cnt - c0), 32'd2);
        check("t2_q", 32'(q), 32'hFF);

        // 3: load during a busy frame is ignored
        repeat (20) @(negedge clk);
        c0 = rx_cnt;
        send_tx(8'h55);
        repeat (200) @(negedge clk);
        d = 8'h3C;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        d = 8'h00;
        wait_idle("t3_timeout");
        repeat (30) @(negedge clk);
        check("t3_still_idle", 32'(txbusy), 32'd0);
        check("t3_rx_count", 32'(rx_cnt - c0), 32'd1);
        check("t3_q", 32'(q), 32'h55);

        // 4: three-tick glitch is a false start
        rx_drv = 1'b1;
        loop_en = 1'b0;
        repeat (30) @(negedge clk);
        c0 = rx_cnt;
        f0 = fe_cnt;
        rx_drv = 1'b0;
        repeat (39) @(negedge clk);
        check("t4_in_start", 32'(rxst), 32'd1);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_rxst_idle", 32'(rxst), 32'd0);
        check("t4_no_byte", 32'(rx_cnt - c0), 32'd0);
        check("t4_no_ferr", 32'(fe_cnt - f0), 32'd0);

        // 5: 8'h81 with low stop bit, line held low 30 ticks more
        c0 = rx_cnt;
        f0 = fe_cnt;
        bits = {8'h81, 1'b0};
        for (int k = 0; k < 9; k++) begin
            rx_drv = bits[k];
            repeat (104) @(negedge clk);
        end
        rx_drv = 1'b0;
        repeat (104 + 390) @(negedge clk);
        check("t5_break_rxst", 32'(rxst), 32'd3);
        check("t5_one_ferr", 32'(fe_cnt - f0), 32'd1);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_rxst_idle", 32'(rxst), 32'd0);
        check("t5_ferr_once", 32'(fe_cnt - f0), 32'd1);
        check("t5_no_byte", 32'(rx_cnt - c0), 32'd0);
        check("t5_q_held", 32'(q), 32'h55);

        // 6: reset mid-frame, then a clean frame
        loop_en = 1'b1;
        repeat (20) @(negedge clk);
        c0 = rx_cnt;
        send_tx(8'hC3);
        repeat (400) @(negedge clk);
        check("t6_mid_rxst", 32'(rxst), 32'd2);
        resetn = 1'b0;
        rst_gen++;
        #1;
        check_reset_vals();
        tx_exp_q.delete();
        rx_exp_q.delete();
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (1200) @(negedge clk);
        check("t6_no_byte", 32'(rx_cnt - c0), 32'd0);
        send_tx(8'h5A);
        wait_idle("t6_timeout");
        check("t6_rx_count", 32'(rx_cnt - c0), 32'd1);
        check("t6_q", 32'(q), 32'h5A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
